gate_vector_sequencer: RTL and testbench
========================================

Name: gate_vector_sequencer

Overview:
- Self-checking stimulus stage for small combinational gates (or, and, xor, nand).
- Upstream side: drives every input combination of an N_IN-input gate in binary-count order and holds each vector for HOLD cycles.
- Downstream side: samples the gate output, compares it with a built-in reference model, then reports the mismatch count and a pass/fail result.
- Replaces hand-written per-vector delays in gate benches with a clocked, reusable block.

Parameters:
- N_IN, 2, number of gate inputs; vector space is 2**N_IN (legal 1..8).
- HOLD, 2, cycles each vector is held before sampling (legal >= 1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- op_sel  input  2  reference op: 0=AND, 1=OR, 2=XOR, 3=NAND; latched on accepted start.
- stim  output  N_IN  vector driven to the gate under test.
- stim_valid  output  1  high while stim holds a vector under test.
- dut_out  input  1  output of the gate under test.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; level, held until next start or rst.
- pass  output  1  valid when done=1: 1 iff err_count==0.
- err_count  output  N_IN+1  mismatches in the current or last sweep; saturates at 2**N_IN.
- cur_idx  output  N_IN  index of the vector currently or last applied.

Behaviour:
- Reset (rst=1 at edge) sets state IDLE and drives stim=0, stim_valid=0, busy=0, done=0, pass=0, err_count=0, cur_idx=0. Internal hold_cnt=0 and latched op=0.
- rst overrides all other inputs, including mid-sweep; a sweep interrupted by rst is discarded with no partial done.
- States: IDLE, DRIVE, DONE.
- IDLE -> DRIVE on start=1:
  - latch op_sel;
  - stim=0, cur_idx=0, hold_cnt=0, err_count=0;
  - stim_valid=1, busy=1, done=0, pass=0.
- DRIVE, each edge with hold_cnt<HOLD-1: hold_cnt+1; stim unchanged.
- DRIVE, edge with hold_cnt==HOLD-1: sample dut_out and compare with the expected value for stim.
  - Mismatch: err_count+1, saturating.
  - cur_idx < 2**N_IN-1: cur_idx+1, stim=cur_idx+1, hold_cnt=0.
  - cur_idx == 2**N_IN-1: go to DONE.
- Timing: vector i is driven for exactly HOLD cycles. done rises 2**N_IN*HOLD edges after the edge that accepted start (8 for defaults).
- DONE: stim_valid=0, busy=0, done=1, pass=(err_count==0).
  - stim and cur_idx hold their last value.
  - start=1 in DONE restarts exactly as from IDLE.
- start while busy=1 is ignored and op_sel changes mid-sweep are ignored.
- Expected value, all ops reduced over the N_IN bits of stim:
  - AND = all bits 1;
  - OR = any bit 1;
  - XOR = odd parity;
  - NAND = inverse of AND.
- dut_out is sampled only on the last hold cycle, so the gate has HOLD-1 full cycles plus one edge to settle.

Optional Feature:
- Macro: GATE_SEQ_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep immediately (DRIVE -> DONE on that sampling edge).
  - err_count=1, pass=0.
  - cur_idx and stim freeze at the failing vector so it can be inspected.
- Undefined: the full sweep always runs and every mismatch is counted.
- No port differences either way.

Decomposition:
- Package gate_seq_pkg:
  - op code constants OP_AND=2'd0, OP_OR=2'd1, OP_XOR=2'd2, OP_NAND=2'd3;
  - state encoding ST_IDLE, ST_DRIVE, ST_DONE.
- Sub-module gate_ref_model: purely combinational, parameter N_IN; inputs vec[N_IN-1:0] and op[1:0]; output expected.
- The sequencer instantiates one gate_ref_model and holds the FSM, hold counter, index counter and error counter.

Test Plan:
- Defaults, op_sel=1, real OR gate on stim/dut_out, start pulse.
  - stim steps 00,01,10,11 for 2 cycles each; done=1 at edge 8; pass=1; err_count=0.
- Same wiring but op_sel=0 (AND expected).
  - Mismatches at vectors 01 and 10; err_count=2, pass=0.
- dut_out tied to 1, op_sel=3 (NAND).
  - Mismatch only at 11; err_count=1, pass=0.
- rst asserted at cycle 3 of a sweep.
  - Next cycle: stim=0, busy=0, done=0, err_count=0; a later start runs a clean full sweep.
- start pulsed again at cycle 4 while busy, then again in DONE.
  - The busy pulse is ignored and timing is unchanged; the DONE pulse restarts and err_count clears.
- GATE_SEQ_STOP_ON_FAIL_EN defined, dut_out tied to 0, op_sel=1.
  - DONE entered at edge 4 with cur_idx=1, stim=01, err_count=1, pass=0.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate vector sequencer: reference op codes and FSM states.
// Optional feature macro used by the sequencer: GATE_SEQ_STOP_ON_FAIL_EN.
package gate_seq_pkg;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate under test: reduces all vec bits by the selected op.
module gate_ref_model
    import gate_seq_pkg::*;
#(
    parameter int unsigned N_IN = 2
) (
    input  logic [N_IN-1:0] vec,
    input  logic [1:0]      op,
    output logic            expected
);

    always_comb begin
        expected = 1'b0;
        case (op)
            OP_AND:  expected = &vec;
            OP_OR:   expected = |vec;
            OP_XOR:  expected = ^vec;
            OP_NAND: expected = ~&vec;
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Sweeps all 2**N_IN input vectors through a gate, HOLD cycles each, and scores its output.
// Define GATE_SEQ_STOP_ON_FAIL_EN to end the sweep on the first mismatch.
module gate_vector_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned N_IN = 2,
    parameter int unsigned HOLD = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op_sel,
    output logic [N_IN-1:0] stim,
    output logic            stim_valid,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] cur_idx
);

    localparam int unsigned    HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] IDX_LAST = '1;
    localparam logic [N_IN:0]  ERR_MAX   = {1'b1, {N_IN{1'b0}}};

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N_IN:0]   err_q, err_d;

    logic expected;
    logic mismatch;
    logic sample;
    logic accept;

    gate_ref_model #(
        .N_IN(N_IN)
    ) u_ref (
        .vec     (idx_q),
        .op      (op_q),
        .expected(expected)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            idx_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    // stim is the vector index itself, so the gate output is scored on the last hold cycle
    always_comb begin
        sample   = (state_q == ST_DRIVE) && (hold_q == HOLD_LAST);
        mismatch = (dut_out != expected);
        accept   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (sample) begin
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
                    if (mismatch || (idx_q == IDX_LAST)) state_d = ST_DONE;
`else
                    if (idx_q == IDX_LAST) state_d = ST_DONE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d   = op_q;
        idx_d  = idx_q;
        hold_d = hold_q;
        err_d  = err_q;
        if (accept) begin
            op_d   = op_sel;
            idx_d  = '0;
            hold_d = '0;
            err_d  = '0;
        end else if (state_q == ST_DRIVE) begin
            if (!sample) begin
                hold_d = hold_q + HW'(1);
            end else begin
                if (mismatch && (err_q != ERR_MAX)) err_d = err_q + (N_IN+1)'(1);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
                if (!mismatch && (idx_q != IDX_LAST)) begin
`else
                if (idx_q != IDX_LAST) begin
`endif
                    idx_d  = idx_q + N_IN'(1);
                    hold_d = '0;
                end
            end
        end
    end

    always_comb begin
        stim       = idx_q;
        cur_idx    = idx_q;
        busy       = (state_q == ST_DRIVE);
        stim_valid = (state_q == ST_DRIVE);
        done       = (state_q == ST_DONE);
        pass       = (state_q == ST_DONE) && (err_q == '0);
        err_count  = err_q;
    end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: table-driven sweeps, randomized faulty gates vs a
// counting model, plus reset-abort and start-while-busy sequences.
module tb_gate_vector_sequencer;

    localparam int N_IN = 2;
    localparam int HOLD = 2;
    localparam int NV   = 1 << N_IN;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // gate modes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 tied 0, 5 tied 1
    localparam int G_AND = 0, G_OR = 1, G_XOR = 2, G_NAND = 3, G_TIE0 = 4, G_TIE1 = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      op_sel = 2'd0;
    logic [N_IN-1:0] stim;
    logic            stim_valid;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] cur_idx;

    int gmode = G_OR;
    bit flip [NV];

    int checks = 0;
    int errors = 0;

    gate_vector_sequencer #(
        .N_IN(N_IN),
        .HOLD(HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sel    (op_sel),
        .stim      (stim),
        .stim_valid(stim_valid),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .cur_idx   (cur_idx)
    );

    always #5 clk = ~clk;

    function automatic int popcount(input int v);
        int c = 0;
        for (int b = 0; b < N_IN; b++) c += (v >> b) & 1;
        return c;
    endfunction

    function automatic bit truth(input int mode, input int v);
        int p = popcount(v);
        case (mode)
            G_AND:   return p == N_IN;
            G_OR:    return p > 0;
            G_XOR:   return (p % 2) == 1;
            G_NAND:  return p != N_IN;
            G_TIE1:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb dut_out = truth(gmode, int'(stim)) ^ flip[stim];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: count vectors where the gate disagrees with the op; find the first one.
    task automatic model(input int op, output int n_err, output int first);
        n_err = 0;
        first = -1;
        for (int i = 0; i < NV; i++) begin
            if ((truth(gmode, i) ^ flip[i]) != truth(op, i)) begin
                n_err++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic sweep(input string tag, input int op, input int exp_err, input bit exp_pass,
                         input bit poke);
        int n_err, first, exp_edge, exp_idx, edges, bad;
        model(op, n_err, first);
        exp_edge = (STOP && first >= 0) ? (first + 1) * HOLD : NV * HOLD;
        exp_idx  = (STOP && first >= 0) ? first : NV - 1;

        @(negedge clk);
        start  = 1'b1;
        op_sel = 2'(op);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".acc_busy"}, int'(busy), 1);
        check({tag, ".acc_err"}, int'(err_count), 0);

        edges = 0;
        bad   = 0;
        while (!done && edges < NV * HOLD + 4) begin
            if (busy && (int'(stim) != edges / HOLD || !stim_valid)) bad++;
            op_sel = 2'($urandom);
            if (poke && edges == 3) begin
                start  = 1'b1;
                op_sel = 2'(~op);
            end
            @(posedge clk);
            edges++;
            #1;
            start = 1'b0;
        end
        check({tag, ".stim_seq"}, bad, 0);
        check({tag, ".done_edge"}, edges, exp_edge);
        check({tag, ".err"}, int'(err_count), exp_err);
        check({tag, ".pass"}, int'(pass), int'(exp_pass));
        check({tag, ".cur_idx"}, int'(cur_idx), exp_idx);
        check({tag, ".stim_hold"}, int'(stim), exp_idx);
        check({tag, ".idle_out"}, int'({busy, stim_valid}), 0);
    endtask

    typedef struct {
        string name;
        int    op;
        int    gm;
        int    err;
        bit    pss;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n_err, first, e;

        tbl[0] = '{"or_or",     1, G_OR,   0, 1'b1};
        tbl[1] = '{"and_or",    0, G_OR,   2, 1'b0};
        tbl[2] = '{"nand_tie1", 3, G_TIE1, 1, 1'b0};
        tbl[3] = '{"xor_xor",   2, G_XOR,  0, 1'b1};
        tbl[4] = '{"xor_tie0",  2, G_TIE0, 2, 1'b0};
        tbl[5] = '{"and_tie0",  0, G_TIE0, 1, 1'b0};

        for (int i = 0; i < NV; i++) flip[i] = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.stim", int'(stim), 0);
        check("rst.valid", int'(stim_valid), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.pass", int'(pass), 0);
        check("rst.err", int'(err_count), 0);
        check("rst.idx", int'(cur_idx), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            gmode = tbl[t].gm;
            e = STOP ? int'(tbl[t].err != 0) : tbl[t].err;
            sweep(tbl[t].name, tbl[t].op, e, tbl[t].pss, 1'b0);
        end

        // start while busy is ignored; the following DONE start must clear err_count
        gmode = G_OR;
        sweep("pre_poke", 0, STOP ? 1 : 2, 1'b0, 1'b0);
        sweep("poke", 1, 0, 1'b1, 1'b1);

        // reset three cycles into a sweep that has already logged an error
        gmode = G_TIE0;
        @(negedge clk);
        start  = 1'b1;
        op_sel = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort.pre_err", int'(err_count), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.stim", int'(stim), 0);
        check("abort.busy", int'(busy), 0);
        check("abort.done", int'(done), 0);
        check("abort.err", int'(err_count), 0);
        check("abort.idx", int'(cur_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        gmode = G_OR;
        sweep("after_abort", 1, 0, 1'b1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            int op;
            op    = int'($urandom_range(0, 3));
            gmode = int'($urandom_range(0, 5));
            for (int i = 0; i < NV; i++) flip[i] = ($urandom_range(0, 3) == 0);
            model(op, n_err, first);
            e = STOP ? int'(n_err != 0) : n_err;
            sweep("rand", op, e, n_err == 0, r[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
